// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single sram-like slave. Data normally wins;
// instruction requests are forced through after STARVE_MAX consecutive data
// grants. Only one slave transaction is ever outstanding.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;          // 0: inst, 1: data
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       grant_data;
    logic       in_addr;
    logic       addr_hit;
    logic       done_hit;

    // Next-state: arbitration in IDLE, then wait for slave handshakes.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        grant_data   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inst_req || data_req) begin
                    state_d    = StAddr;
                    grant_data = data_req && !(inst_req && (starve_cnt_q == StarveMax));
                    owner_d    = grant_data;
                    // Count only data grants that make a waiting inst request wait longer.
                    if (grant_data && inst_req) begin
                        starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q
                                                                   : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end
            end
            StAddr: begin
                if (s_addr_ok) begin
                    state_d = s_data_ok ? StIdle : StData;
                end
            end
            StData: begin
                if (s_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Outputs: slave command muxed from the owner, handshakes routed back to it.
    // Everything is gated by reset so an in-flight completion is silently dropped.
    always_comb begin
        in_addr  = !reset && (state_q == StAddr);
        addr_hit = in_addr && s_addr_ok;
        done_hit = (addr_hit && s_data_ok) || (!reset && (state_q == StData) && s_data_ok);

        s_req    = in_addr;
        s_wr     = owner_q ? data_wr    : inst_wr;
        s_size   = owner_q ? data_size  : inst_size;
        s_wstrb  = owner_q ? data_wstrb : inst_wstrb;
        s_addr   = owner_q ? data_addr  : inst_addr;
        s_wdata  = owner_q ? data_wdata : inst_wdata;

        inst_addr_ok = addr_hit && !owner_q;
        data_addr_ok = addr_hit && owner_q;
        inst_data_ok = done_hit && !owner_q;
        data_data_ok = done_hit && owner_q;
        inst_rdata   = s_rdata;
        data_rdata   = s_rdata;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: random masters and a random-latency slave,
// with a grant-order reference model and per-master expected-transaction queues.
module tb_sram_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int OwnNone = 0;
    localparam int OwnInst = 1;
    localparam int OwnData = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Slave memory contents: any address reads back as a fixed scramble of itself.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a ^ 32'h1E80_0000;
    endfunction

    // Expected transactions, oldest first, per master.
    cmd_t iq[$];
    cmd_t dq[$];
    int   gseq[$];

    // Stimulus knobs.
    int p_inst, p_data;
    int a_min, a_max, d_min, d_max;
    bit spur_en, rst_on_data;

    // Slave model state.
    int          sl_phase, sl_cnt;
    logic [31:0] sl_addr;
    logic        i_acc, d_acc;

    task automatic drive_inst(input cmd_t c);
        inst_req = 1'b1; inst_addr = c.addr; inst_wr = c.wr; inst_size = c.size;
        inst_wstrb = c.wstrb; inst_wdata = c.wdata;
        iq.push_back(c);
    endtask

    task automatic drive_data(input cmd_t c);
        data_req = 1'b1; data_addr = c.addr; data_wr = c.wr; data_size = c.size;
        data_wstrb = c.wstrb; data_wdata = c.wdata;
        dq.push_back(c);
    endtask

    function automatic cmd_t rand_cmd(input logic [3:0] region);
        cmd_t c;
        c.addr  = {region, 28'($urandom)};
        c.wr    = 1'($urandom_range(1));
        c.size  = 2'($urandom_range(3));
        c.wstrb = 4'($urandom);
        c.wdata = $urandom;
        return c;
    endfunction

    task automatic drop_all();
        inst_req = 1'b0; data_req = 1'b0;
        iq.delete(); dq.delete();
        sl_phase = 0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drop_all();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One clock of masters plus slave; inputs change 1 time unit after the edge.
    task automatic step();
        int d;
        @(negedge clk);
        i_acc = inst_addr_ok;
        d_acc = data_addr_ok;
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (inst_req && i_acc) inst_req = 1'b0;
        if (data_req && d_acc) data_req = 1'b0;
        if (!inst_req && $urandom_range(99) < p_inst) drive_inst(rand_cmd(4'h1));
        if (!data_req && $urandom_range(99) < p_data) drive_data(rand_cmd(4'h8));

        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = $urandom;
        if (sl_phase == 0 && s_req) begin
            sl_phase = 1;
            sl_cnt   = $urandom_range(a_max, a_min);
        end
        if (sl_phase == 1) begin
            if (sl_cnt == 0) begin
                s_addr_ok = 1'b1;
                sl_addr   = s_addr;
                d         = $urandom_range(d_max, d_min);
                if (d == 0) begin
                    s_data_ok = 1'b1;
                    s_rdata   = mem_rd(sl_addr);
                    sl_phase  = 0;
                end else begin
                    sl_phase = 2;
                    sl_cnt   = d - 1;
                end
            end else begin
                sl_cnt--;
            end
        end else if (sl_phase == 2) begin
            if (sl_cnt == 0) begin
                s_data_ok = 1'b1;
                s_rdata   = mem_rd(sl_addr);
                sl_phase  = 0;
                if (rst_on_data) begin
                    reset       = 1'b1;
                    rst_on_data = 1'b0;
                    inst_req = 1'b0; data_req = 1'b0;
                    iq.delete(); dq.delete();
                end
            end else begin
                sl_cnt--;
            end
        end else if (spur_en && !s_req && $urandom_range(3) == 0) begin
            s_addr_ok = 1'b1;
            s_data_ok = 1'(($urandom_range(1)));
        end
    endtask

    // Monitor / reference model state.
    int   own = OwnNone;
    int   streak = 0;
    int   exp_own, act_own;
    bit   prev_idle = 0, idle_now, after_rst = 0, after_done = 0, addr_done = 0;
    logic prev_i = 0, prev_d = 0;
    cmd_t mc;

    // Checks every cycle on the falling edge, away from where inputs change.
    always @(negedge clk) begin
        if (reset) begin
            check("reset quiet", 32'({s_req, inst_addr_ok, inst_data_ok, data_addr_ok,
                                      data_data_ok}), 32'd0);
            own = OwnNone; streak = 0; prev_idle = 0; after_rst = 1; after_done = 0;
        end else begin
            idle_now = (own == OwnNone) && !s_req;
            if (after_rst) check("post-reset s_req", 32'(s_req), 32'd0);
            if (after_done) check("idle after done", 32'(s_req), 32'd0);
            if (idle_now) check("idle quiet", 32'({inst_addr_ok, inst_data_ok, data_addr_ok,
                                                   data_data_ok}), 32'd0);

            if (own == OwnNone && s_req) begin
                check("grant follows idle", 32'(prev_idle), 32'd1);
                if (prev_d && !(prev_i && streak >= int'(STARVE_MAX))) exp_own = OwnData;
                else if (prev_i) exp_own = OwnInst;
                else exp_own = OwnNone;
                act_own = s_addr[31] ? OwnData : OwnInst;
                check("grant owner", 32'(act_own), 32'(exp_own));
                if (act_own == OwnData && prev_i) streak = streak + 1;
                else streak = 0;
                gseq.push_back(act_own);
                own = act_own;
                addr_done = 0;
            end else if (prev_idle && (prev_i || prev_d)) begin
                check("grant latency", 32'(s_req), 32'd1);
            end

            if (s_req && own != OwnNone) begin
                if ((own == OwnInst ? iq.size() : dq.size()) == 0) begin
                    check("owner has command", 32'd0, 32'd1);
                end else begin
                    mc = (own == OwnInst) ? iq[0] : dq[0];
                    check("s_addr", s_addr, mc.addr);
                    check("s_wr/size/wstrb", 32'({s_wr, s_size, s_wstrb}),
                          32'({mc.wr, mc.size, mc.wstrb}));
                    check("s_wdata", s_wdata, mc.wdata);
                end
            end

            if (inst_addr_ok || data_addr_ok) begin
                check("addr_ok target", 32'({inst_addr_ok, data_addr_ok}),
                      own == OwnInst ? 32'd2 : own == OwnData ? 32'd1 : 32'd0);
                check("addr_ok once", 32'(addr_done), 32'd0);
                addr_done = 1;
            end

            after_done = 0;
            if (inst_data_ok || data_data_ok) begin
                check("data_ok target", 32'({inst_data_ok, data_data_ok}),
                      own == OwnInst ? 32'd2 : own == OwnData ? 32'd1 : 32'd0);
                check("data_ok after addr_ok", 32'(addr_done), 32'd1);
                check("inst_rdata passthru", inst_rdata, s_rdata);
                check("data_rdata passthru", data_rdata, s_rdata);
                if ((own == OwnInst ? iq.size() : dq.size()) == 0) begin
                    check("completion has command", 32'd0, 32'd1);
                end else begin
                    mc = (own == OwnInst) ? iq.pop_front() : dq.pop_front();
                    if (!mc.wr) begin
                        check("read data", own == OwnInst ? inst_rdata : data_rdata,
                              mem_rd(mc.addr));
                    end
                end
                own = OwnNone;
                after_done = 1;
            end

            prev_idle = idle_now;
            prev_i    = inst_req;
            prev_d    = data_req;
            after_rst = 0;
        end
    end

    initial begin
        automatic cmd_t c;
        automatic int pat[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        automatic int guard;
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
        p_inst = 0; p_data = 0; spur_en = 0; rst_on_data = 0;
        a_min = 1; a_max = 1; d_min = 2; d_max = 2;
        reset_dut();

        // Single instruction fetch with fixed slave latencies.
        c = '{addr: 32'h1C00_0000, wr: 1'b0, size: 2'd2, wstrb: 4'hF, wdata: 32'd0};
        drive_inst(c);
        repeat (8) step();

        // Simultaneous requests: data first, then inst.
        gseq.delete();
        drive_inst(rand_cmd(4'h1));
        drive_data(rand_cmd(4'h8));
        repeat (14) step();
        check("both-req first grant", gseq.size() > 0 ? 32'(gseq[0]) : 32'd0, 32'd2);
        check("both-req second grant", gseq.size() > 1 ? 32'(gseq[1]) : 32'd0, 32'd1);

        // Slave answers addr and data in the same cycle.
        a_min = 0; a_max = 2; d_min = 0; d_max = 0;
        for (int i = 0; i < 4; i++) begin
            drive_inst(rand_cmd(4'h1));
            repeat (5) step();
        end

        // Spurious slave handshakes with nobody requesting.
        spur_en = 1;
        repeat (12) step();
        spur_en = 0;

        // Reset lands together with the completing s_data_ok.
        a_min = 0; a_max = 0; d_min = 2; d_max = 2;
        rst_on_data = 1;
        drive_inst(rand_cmd(4'h1));
        repeat (6) step();

        // Both masters saturating: starvation limit shapes the grant order.
        reset_dut();
        gseq.delete();
        a_min = 0; a_max = 2; d_min = 0; d_max = 2;
        p_inst = 100; p_data = 100;
        guard = 0;
        while (gseq.size() < 10 && guard < 300) begin
            step();
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("starve seq[%0d]", i), gseq.size() > i ? 32'(gseq[i]) : 32'd0,
                  32'(pat[i]));
        end

        // Random traffic.
        p_inst = 40; p_data = 50; a_min = 0; a_max = 3; d_min = 0; d_max = 3; spur_en = 1;
        repeat (3000) step();

        // Drain: every issued transaction must complete.
        p_inst = 0; p_data = 0;
        guard = 0;
        while ((iq.size() != 0 || dq.size() != 0) && guard < 100) begin
            step();
            guard++;
        end
        check("drained", 32'(iq.size() + dq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive data grants allowed while inst_req is pending before inst is forced; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_req  in  1  instruction master request; held until inst_addr_ok.
REQ-005 inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  in  1/2/4/32/32  instruction master command fields.
REQ-006 inst_addr_ok  out  1  instruction master request accepted.
REQ-007 inst_data_ok  out  1  instruction master transaction complete.
REQ-008 inst_rdata  out  32  read data returned to the instruction master.
REQ-009 data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data master request and command fields; same rules as the inst master.
REQ-010 data_addr_ok / data_data_ok / data_rdata  out  1/1/32  data master responses.
REQ-011 s_req / s_wr / s_size / s_wstrb / s_addr / s_wdata  out  1/1/2/4/32/32  shared sram-like slave command.
REQ-012 s_addr_ok / s_data_ok / s_rdata  in  1/1/32  slave responses.

Function
REQ-013 FSM states: IDLE, ADDR, DATA; at most one slave transaction outstanding.
REQ-014 IDLE: if any request, latch owner, go to ADDR; s_req=0 in IDLE.
REQ-015 Owner select: data beats inst, except inst wins when starve_cnt==STARVE_MAX and inst_req=1.
REQ-016 starve_cnt (4 bits): +1 on a data grant while inst_req=1; cleared on any inst grant or when inst_req=0 at a grant; saturates at STARVE_MAX.
REQ-017 ADDR: s_req=1; s_* command fields driven combinationally from the owner's inputs; stay until s_addr_ok.
REQ-018 ADDR and s_addr_ok: owner's *_addr_ok=1 that cycle only; next state DATA; if s_data_ok is also 1 that cycle, complete directly (REQ-019) and go to IDLE.
REQ-019 DATA: on s_data_ok, owner's *_data_ok=1 for exactly that cycle, *_rdata=s_rdata, next state IDLE.
REQ-020 Non-owner addr_ok/data_ok are 0 at all times; both rdata outputs equal s_rdata.
REQ-021 Minimum latency: req in IDLE cycle N -> s_req at N+1 -> addr_ok earliest N+1 -> data_ok earliest N+1 (same-cycle slave) else N+2.
REQ-022 Back-to-back: IDLE entered after completion may grant the next request the following cycle; no combinational path from s_data_ok to grant.
REQ-023 s_addr_ok or s_data_ok outside their state is ignored; no output effect.
REQ-024 Master dropping req in ADDR is a protocol violation; behaviour unspecified, no recovery required.
REQ-025 Writes complete on s_data_ok like reads; rdata is don't-care to the master.

Reset
REQ-026 reset=1 at any clock edge: state IDLE, owner=inst, starve_cnt=0; in-flight transaction discarded, no data_ok issued.
REQ-027 While in reset and the cycle after: s_req, all *_addr_ok, all *_data_ok are 0.

Verification
REQ-028 Only inst_req, addr 0x1C000000, slave addr_ok 1 cycle later, data_ok 2 later with rdata 0x02800000 -> s_addr=0x1C000000, inst_addr_ok pulse, inst_data_ok pulse with inst_rdata 0x02800000, data_* stay 0.
REQ-029 inst_req and data_req both asserted in IDLE -> data granted first, s_wr/s_addr follow data master, inst granted on the next IDLE.
REQ-030 inst_req held high, data_req held high, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-031 Slave asserts s_addr_ok and s_data_ok in the same cycle -> addr_ok and data_ok both pulse to owner that cycle; FSM in IDLE next cycle.
REQ-032 reset asserted in DATA state with s_data_ok arriving in the same cycle -> no data_ok to either master; IDLE with s_req=0 the next cycle.
REQ-033 Spurious s_data_ok=1 in IDLE with no requests -> all master outputs 0, state unchanged.
